// File: rtl/sparse_conv_mc.sv
// Time-multiplexed sparse-coefficient convolution engine, one shared accumulator.
// Define SPARSE_CONV_ROUND_EN to round half up in each group shift instead of truncating.
module sparse_conv_mc #(
   parameter int CHANNELS     = 2,
   parameter int DATA_W       = 16,
   parameter int OUT_W        = 40,
   parameter int NUM_RJ       = 16,
   parameter int RJ_W         = 8,
   parameter int COEFF_ADDR_W = 9,
   parameter int DEPTH        = 256,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int RJA_W = $clog2(NUM_RJ)
) (
   input  logic                    sclk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [PTR_W-1:0]        sample_ptr,
   output logic [CH_W-1:0]         ch_sel,
   output logic [RJA_W-1:0]        rj_addr,
   input  logic [RJ_W-1:0]         rj_data,
   output logic [COEFF_ADDR_W-1:0] coeff_addr,
   input  logic [PTR_W:0]          coeff_data,
   output logic [PTR_W-1:0]        data_addr,
   input  logic [DATA_W-1:0]       data_data,
   output logic                    busy,
   output logic                    out_valid,
   output logic [CH_W-1:0]         out_ch,
   output logic [OUT_W-1:0]        out_data,
   output logic                    done,
   output logic                    overrun
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD_RJ = 3'd1;
   localparam logic [2:0] ACCUM   = 3'd2;
   localparam logic [2:0] SHIFT   = 3'd3;
   localparam logic [2:0] EMIT    = 3'd4;

   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
   localparam logic [RJA_W-1:0] LAST_RJ  = RJA_W'(NUM_RJ - 1);
   localparam logic [PTR_W-1:0] CNT_MAX  = PTR_W'(DEPTH - 1);

   logic [2:0]              state;
   logic [PTR_W-1:0]        ptr;
   logic [CH_W-1:0]         ch;
   logic [RJA_W-1:0]        j;
   logic [COEFF_ADDR_W-1:0] cidx;
   logic [RJ_W-1:0]         cnt;
   logic [OUT_W-1:0]        acc;
   logic [PTR_W-1:0]        sampleCnt;

   logic [PTR_W-1:0]        kIdx;
   logic                    negTerm;
   logic [OUT_W-1:0]        dataExt;
   logic [OUT_W-1:0]        term;
   logic [OUT_W-1:0]        accSum;
   logic [OUT_W-1:0]        accHalf;

   assign ch_sel     = ch;
   assign rj_addr    = j;
   assign coeff_addr = cidx;
   assign kIdx       = coeff_data[PTR_W-1:0];
   assign negTerm    = coeff_data[PTR_W];
   assign data_addr  = ptr - kIdx;
   assign busy       = (state != IDLE);

   // Taps older than the number of samples seen so far read stale memory.
   always_comb begin
      dataExt = {{(OUT_W-DATA_W){data_data[DATA_W-1]}}, data_data};
      term    = '0;
      if (kIdx <= sampleCnt) begin
         term = dataExt << DATA_W;
      end
      accSum = negTerm ? (acc - term) : (acc + term);
   end

`ifdef SPARSE_CONV_ROUND_EN
   logic [OUT_W-1:0] accInc;
   assign accInc  = acc + OUT_W'(1);
   assign accHalf = OUT_W'($signed(accInc) >>> 1);
`else
   assign accHalf = OUT_W'($signed(acc) >>> 1);
`endif

   always_ff @(posedge sclk) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         ch        <= '0;
         j         <= '0;
         cidx      <= '0;
         cnt       <= '0;
         acc       <= '0;
         sampleCnt <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
         overrun   <= start && (state != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  ptr   <= sample_ptr;
                  ch    <= '0;
                  j     <= '0;
                  cidx  <= '0;
                  acc   <= '0;
                  state <= LOAD_RJ;
               end
            end
            LOAD_RJ: begin
               cnt   <= rj_data;
               state <= (rj_data == '0) ? SHIFT : ACCUM;
            end
            ACCUM: begin
               acc  <= accSum;
               cidx <= cidx + COEFF_ADDR_W'(1);
               cnt  <= cnt - RJ_W'(1);
               if (cnt == RJ_W'(1)) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc   <= accHalf;
               j     <= j + RJA_W'(1);
               state <= (j == LAST_RJ) ? EMIT : LOAD_RJ;
            end
            EMIT: begin
               out_data  <= acc;
               out_ch    <= ch;
               out_valid <= 1'b1;
               if (ch == LAST_CH) begin
                  done  <= 1'b1;
                  state <= IDLE;
                  if (sampleCnt != CNT_MAX) begin
                     sampleCnt <= sampleCnt + PTR_W'(1);
                  end
               end else begin
                  ch    <= ch + CH_W'(1);
                  acc   <= '0;
                  j     <= '0;
                  cidx  <= '0;
                  state <= LOAD_RJ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sparse_conv_mc.sv
// Scoreboard bench for sparse_conv_mc: directed vectors, monitor-side checking.
module tb_sparse_conv_mc;

   localparam int CH    = 2;
   localparam int DW    = 16;
   localparam int OW    = 40;
   localparam int NRJ   = 16;
   localparam int RJW   = 8;
   localparam int CAW   = 9;
   localparam int DEPTH = 256;
   localparam int PW    = 8;
   localparam int CHW   = 1;
   localparam int RJAW  = 4;

   logic           sclk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [PW-1:0]  samplePtr = '0;
   logic [CHW-1:0] chSel;
   logic [RJAW-1:0] rjAddr;
   logic [RJW-1:0] rjData;
   logic [CAW-1:0] coeffAddr;
   logic [PW:0]    coeffData;
   logic [PW-1:0]  dataAddr;
   logic [DW-1:0]  dataData;
   logic           busy;
   logic           outValid;
   logic [CHW-1:0] outCh;
   logic [OW-1:0]  outData;
   logic           done;
   logic           overrun;

   logic [RJW-1:0] rjMem    [CH][NRJ];
   logic [PW:0]    coeffMem [CH][512];
   logic [DW-1:0]  dataMem  [CH][DEPTH];

   sparse_conv_mc dut (
      .sclk       (sclk),
      .reset      (reset),
      .start      (start),
      .sample_ptr (samplePtr),
      .ch_sel     (chSel),
      .rj_addr    (rjAddr),
      .rj_data    (rjData),
      .coeff_addr (coeffAddr),
      .coeff_data (coeffData),
      .data_addr  (dataAddr),
      .data_data  (dataData),
      .busy       (busy),
      .out_valid  (outValid),
      .out_ch     (outCh),
      .out_data   (outData),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 sclk = ~sclk;

   always_comb begin
      rjData    = rjMem[chSel][rjAddr];
      coeffData = coeffMem[chSel][coeffAddr];
      dataData  = dataMem[chSel][dataAddr];
   end

   typedef struct {
      logic [CHW-1:0] ch;
      logic [OW-1:0]  data;
      int             cyc;
      bit             last;
   } exp_t;

   exp_t sbQ[$];
   exp_t mon;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   startCycle = 0;

   always @(posedge sclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   always @(negedge sclk) begin
      if (outValid) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: actual ch=%0d data=%h required none",
                     outCh, outData);
         end else begin
            mon = sbQ.pop_front();
            chk("out_data", 64'(outData), 64'(mon.data));
            chk("out_ch", 64'(outCh), 64'(mon.ch));
            chk("out_cycle", 64'(cyc), 64'(mon.cyc));
            chk("done", 64'(done), 64'(mon.last));
         end
      end else if (done) begin
         checks++;
         errors++;
         $display("FAIL stray_done: actual 1 required 0");
      end
   end

   task automatic clearMem();
      for (int c = 0; c < CH; c++) begin
         for (int i = 0; i < NRJ; i++) rjMem[c][i] = '0;
         for (int i = 0; i < 512; i++) coeffMem[c][i] = '0;
         for (int i = 0; i < DEPTH; i++) dataMem[c][i] = '0;
      end
   endtask

   task automatic launch(input logic [PW-1:0] p,
                         input logic [OW-1:0] d0, input logic [OW-1:0] d1,
                         input int l0, input int l1);
      exp_t e;
      @(negedge sclk);
      samplePtr = p;
      start = 1'b1;
      startCycle = cyc + 1;
      e.ch = 1'b0; e.data = d0; e.cyc = startCycle + l0; e.last = 1'b0;
      sbQ.push_back(e);
      e.ch = 1'b1; e.data = d1; e.cyc = startCycle + l1; e.last = 1'b1;
      sbQ.push_back(e);
      @(negedge sclk);
      start = 1'b0;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge sclk);
         if (sbQ.size() == 0 && !busy) return;
      end
      checks++;
      errors++;
      $display("FAIL timeout: actual busy=%0d pending=%0d required idle",
               busy, sbQ.size());
      sbQ.delete();
   endtask

   task automatic doReset();
      @(negedge sclk);
      reset = 1'b0;
      @(negedge sclk);
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      clearMem();
      repeat (3) @(negedge sclk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_valid", 64'(outValid), 64'd0);
      chk("rst_out_data", 64'(outData), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_ch_sel", 64'(chSel), 64'd0);
      reset = 1'b1;

      // All rj zero: pure shift latency, zero output.
      launch(8'd0, 40'h0, 40'h0, 33, 66);
      waitIdle();

      // Single positive tap, group 0 on ch0 and group 15 on ch1.
      clearMem();
      rjMem[0][0] = 8'd1;
      rjMem[1][15] = 8'd1;
      dataMem[0][10] = 16'h0001;
      dataMem[1][10] = 16'h0001;
      launch(8'd10, 40'h0000000001, 40'h0000008000, 34, 68);
      waitIdle();

      // Negative taps.
      coeffMem[0][0] = 9'h100;
      coeffMem[1][0] = 9'h100;
      launch(8'd10, 40'hFFFFFFFFFF, 40'hFFFFFF8000, 34, 68);
      waitIdle();

      // Multi-coefficient groups: cidx runs across groups.
      clearMem();
      rjMem[0][0] = 8'd2;
      rjMem[0][1] = 8'd1;
      coeffMem[0][0] = 9'h000;
      coeffMem[0][1] = 9'h001;
      coeffMem[0][2] = 9'h102;
      dataMem[0][20] = 16'd4;
      dataMem[0][19] = 16'd2;
      dataMem[0][18] = 16'd8;
      launch(8'd20, 40'hFFFFFFFFF6, 40'h0, 36, 69);
      waitIdle();

      // Fresh history: k=3 suppressed until three starts have completed.
      doReset();
      chk("rst2_out_data", 64'(outData), 64'd0);
      clearMem();
      for (int c = 0; c < CH; c++) begin
         rjMem[c][0] = 8'd1;
         coeffMem[c][0] = 9'h003;
         dataMem[c][255] = 16'h7FFF;
      end
      for (int s = 0; s < 3; s++) begin
         launch(8'd2, 40'h0, 40'h0, 34, 68);
         waitIdle();
      end
      launch(8'd2, 40'h0000007FFF, 40'h0000007FFF, 34, 68);
      waitIdle();

      // Start during ACCUM: overrun only.
      launch(8'd2, 40'h0000007FFF, 40'h0000007FFF, 34, 68);
      chk("busy_after_start", 64'(busy), 64'd1);
      @(negedge sclk);
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
      chk("overrun_pulse", 64'(overrun), 64'd1);
      @(negedge sclk);
      chk("overrun_clear", 64'(overrun), 64'd0);
      waitIdle();
      repeat (80) @(negedge sclk);

      // Reset mid-ACCUM aborts and clears sample history.
      @(negedge sclk);
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
      @(negedge sclk);
      reset = 1'b0;
      @(negedge sclk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_valid", 64'(outValid), 64'd0);
      chk("abort_out_data", 64'(outData), 64'd0);
      reset = 1'b1;
      repeat (80) @(negedge sclk);
      launch(8'd2, 40'h0, 40'h0, 34, 68);
      waitIdle();

      repeat (5) @(negedge sclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sparse_conv_mc.md
Name: sparse_conv_mc

Overview:
Parametrised, time-multiplexed sparse-coefficient convolution engine. It is the successor to the fixed stereo convolution unit and serves CHANNELS channels with one shared accumulator. On each start it processes channels 0..CHANNELS-1 in sequence and emits one OUT_W result per channel. The surrounding MSDAP-style top holds the per-channel rj, coeff and data memories, muxes them by ch_sel, and provides combinational reads.

Parameters:
CHANNELS, 2, number of channels processed per start
DATA_W, 16, input sample width (two's complement)
OUT_W, 40, accumulator/output width
NUM_RJ, 16, number of rj entries (power-of-two groups)
RJ_W, 8, rj entry width (coefficients per group)
COEFF_ADDR_W, 9, coeff memory address width
DEPTH, 256, data memory depth (circular, power of two); coeff index k is log2(DEPTH) bits, sign bit above

Ports:
sclk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse: new sample written to all channels
sample_ptr  in  log2(DEPTH)  data memory address of newest sample x[n]
ch_sel  out  log2(CHANNELS) (min 1)  channel whose memories must be presented
rj_addr  out  log2(NUM_RJ)  rj read address
rj_data  in  RJ_W  rj[rj_addr] of ch_sel (combinational)
coeff_addr  out  COEFF_ADDR_W  coeff read address
coeff_data  in  log2(DEPTH)+1  {sign, k}
data_addr  out  log2(DEPTH)  data read address
data_data  in  DATA_W  x at data_addr of ch_sel
busy  out  1  high outside IDLE
out_valid  out  1  one-cycle pulse, out_data/out_ch valid
out_ch  out  log2(CHANNELS) (min 1)  channel of out_data
out_data  out  OUT_W  convolution result, held until next out_valid
done  out  1  one-cycle pulse after last channel emitted
overrun  out  1  one-cycle pulse: start received while busy

Behaviour:
- Reset (reset==0 at sclk edge): state IDLE; every output 0; acc=0; sample_cnt=0. Applies in any state and aborts work in progress without emitting out_valid or done.
- sample_cnt: counts processed starts. It saturates at DEPTH-1 and increments on the done cycle.
- IDLE: on start, latch sample_ptr, set ch=0, j=0, cidx=0, acc=0 and go to LOAD_RJ. busy rises the cycle after start.
- LOAD_RJ: rj_addr=j. Latch cnt=rj_data. If cnt==0 go to SHIFT, else go to ACCUM.
- ACCUM (one coefficient per cycle):
  - coeff_addr=cidx; k=coeff_data[low bits]; data_addr=(ptr-k) mod DEPTH.
  - term = sign-extend(data_data) << DATA_W, forced to 0 if k>sample_cnt.
  - acc = acc - term if the sign bit is 1, else acc + term. Arithmetic is modulo 2^OUT_W.
  - cidx++ and cnt--. When cnt reaches 0 go to SHIFT.
- SHIFT: acc = acc >>> 1 (arithmetic), then j++. If j==NUM_RJ go to EMIT, else go to LOAD_RJ.
- cidx is not cleared between groups; the coeff memory is the concatenation of all groups. cidx wraps modulo 2^COEFF_ADDR_W.
- EMIT: out_data=acc, out_ch=ch, out_valid=1 for one cycle.
  - If ch==CHANNELS-1: done=1 the same cycle, go to IDLE.
  - Otherwise: ch++, acc=0, j=0, cidx=0, go to LOAD_RJ.
- Per-channel latency = sum over j of (2 + rj[j]) + 1 cycles.
- Start while busy: ignored, overrun=1 for one cycle, state unaffected. Start in the EMIT cycle of the last channel is also an overrun.
- ch_sel=ch at all times; all read addresses are combinational from state.

Optional Feature:
SPARSE_CONV_ROUND_EN: when defined, SHIFT computes acc=(acc + 1) >>> 1 (round half up, wrapping). When undefined, SHIFT truncates (plain >>> 1). All other timing is identical.

Test Plan:
- All rj=0, CHANNELS=2, start -> out_valid at cycles 33 and 66 after start, out_data=0 for both, done with second out_valid.
- Ch0: rj[0]=1, coeff[0]={0,0}, x[n]=16'h0001 -> out_data=40'h0000000001. Ch1: rj[15]=1 (others 0), same coeff/x -> out_data=40'h0000008000 (truncate build).
- Ch0: rj[0]=1, coeff[0]={1,0}, x=16'h0001 -> out_data=40'hFFFFFFFFFF. With SPARSE_CONV_ROUND_EN and rj[15]=1, x=1, sign=1 -> 40'hFFFFFF8000.
- First start after reset with coeff k=3 and data_data=16'h7FFF -> term suppressed, out_data=0. After 3 more starts (sample_cnt=3) -> nonzero result equal to the reference model.
- Start pulsed during ACCUM -> overrun pulse, out_data and done timing unchanged, no extra results.
- reset low for one cycle mid-ACCUM on ch0 -> next cycle busy=0, out_valid=0, done never pulses. The following start gives a result as if from power-up (sample_cnt=0).
